// File: rtl/api_tx_arb.sv
// Packet-atomic arbiter sharing the API tx FIFO write port between two work sources.
// Optional per-source packet counters: define API_TX_ARB_STAT_EN.
module api_tx_arb #(
    parameter int WORK_LEN      = 23,
    parameter int TX_FIFO_DEPTH = 512,
    parameter int CNT_W         = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       reg_src_en,
    input  logic             reg_strict,
    input  logic [CNT_W-1:0] src0_count,
    output logic             src0_rd_en,
    input  logic [31:0]      src0_dout,
    input  logic [CNT_W-1:0] src1_count,
    output logic             src1_rd_en,
    input  logic [31:0]      src1_dout,
    input  logic [CNT_W-1:0] tx_fifo_data_count,
    output logic             tx_fifo_wr_en,
    output logic [31:0]      tx_fifo_din,
    output logic             busy,
`ifdef API_TX_ARB_STAT_EN
    input  logic             stat_clr,
    output logic [15:0]      pkt_cnt0,
    output logic [15:0]      pkt_cnt1,
`endif
    output logic             cur_src
);

    localparam int WCW = $clog2(WORK_LEN + 1);
    localparam logic [WCW-1:0]   LAST_WORD = WCW'(WORK_LEN - 1);
    localparam logic [CNT_W:0]   DEPTH_W   = (CNT_W + 1)'(TX_FIFO_DEPTH);
    localparam logic [CNT_W:0]   LEN_W     = (CNT_W + 1)'(WORK_LEN);

    typedef enum logic [1:0] {IDLE, XFER, GAP} state_t;

    state_t         state, state_nx;
    logic [WCW-1:0] word_cnt, word_cnt_nx;
    logic           gap_cnt, gap_cnt_nx;
    logic           rr_ptr, rr_nx;
    logic           cur_nx;
    logic           last_pop;
    logic           xfer;
    logic           src0_ok, src1_ok, space_ok, winner;
    logic [CNT_W:0] fill, space;

    // An overfull count (above depth) must read as "no space", not wrap to a large value.
    assign fill     = {1'b0, tx_fifo_data_count};
    assign space    = DEPTH_W - fill;
    assign space_ok = (fill <= DEPTH_W) && (space >= LEN_W);

    assign src0_ok = reg_src_en[0] && (src0_count >= CNT_W'(WORK_LEN));
    assign src1_ok = reg_src_en[1] && (src1_count >= CNT_W'(WORK_LEN));

    always_comb begin
        if (reg_strict || !rr_ptr) winner = !src0_ok;
        else                       winner = src1_ok;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            word_cnt <= '0;
            gap_cnt  <= 1'b0;
            rr_ptr   <= 1'b0;
            cur_src  <= 1'b0;
        end else begin
            state    <= state_nx;
            word_cnt <= word_cnt_nx;
            gap_cnt  <= gap_cnt_nx;
            rr_ptr   <= rr_nx;
            cur_src  <= cur_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        word_cnt_nx = word_cnt;
        gap_cnt_nx  = gap_cnt;
        rr_nx       = rr_ptr;
        cur_nx      = cur_src;
        last_pop    = 1'b0;
        case (state)
            IDLE: begin
                if (space_ok && (src0_ok || src1_ok)) begin
                    state_nx    = XFER;
                    cur_nx      = winner;
                    word_cnt_nx = '0;
                    rr_nx       = ~winner;
                end
            end
            XFER: begin
                word_cnt_nx = word_cnt + 1'b1;
                if (word_cnt == LAST_WORD) begin
                    state_nx   = GAP;
                    gap_cnt_nx = 1'b0;
                    last_pop   = 1'b1;
                end
            end
            GAP: begin
                gap_cnt_nx = 1'b1;
                if (gap_cnt) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign xfer       = (state == XFER);
    assign src0_rd_en = xfer && !cur_src;
    assign src1_rd_en = xfer &&  cur_src;
    assign busy       = (state != IDLE);

    // FWFT head word is valid alongside rd_en, so register it straight into the tx FIFO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_fifo_wr_en <= 1'b0;
            tx_fifo_din   <= '0;
        end else begin
            tx_fifo_wr_en <= xfer;
            if (xfer) tx_fifo_din <= cur_src ? src1_dout : src0_dout;
        end
    end

`ifdef API_TX_ARB_STAT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_cnt0 <= '0;
            pkt_cnt1 <= '0;
        end else if (stat_clr) begin
            pkt_cnt0 <= '0;
            pkt_cnt1 <= '0;
        end else if (last_pop) begin
            if (cur_src) pkt_cnt1 <= pkt_cnt1 + 16'd1;
            else         pkt_cnt0 <= pkt_cnt0 + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_api_tx_arb.sv
// Randomized bench for api_tx_arb: FIFO models plus a packet-level grant/stream reference.
module tb_api_tx_arb;

    localparam int WL = 23;
    localparam int CW = 10;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [1:0]    reg_src_en;
    logic          reg_strict;
    logic [CW-1:0] src0_count, src1_count, tx_fifo_data_count;
    logic [31:0]   src0_dout, src1_dout, tx_fifo_din;
    logic          src0_rd_en, src1_rd_en, tx_fifo_wr_en, busy, cur_src;
`ifdef API_TX_ARB_STAT_EN
    logic          stat_clr;
    logic [15:0]   pkt_cnt0, pkt_cnt1;
`endif

    api_tx_arb #(.WORK_LEN(WL), .TX_FIFO_DEPTH(512), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .reg_src_en(reg_src_en), .reg_strict(reg_strict),
        .src0_count(src0_count), .src0_rd_en(src0_rd_en), .src0_dout(src0_dout),
        .src1_count(src1_count), .src1_rd_en(src1_rd_en), .src1_dout(src1_dout),
        .tx_fifo_data_count(tx_fifo_data_count), .tx_fifo_wr_en(tx_fifo_wr_en),
        .tx_fifo_din(tx_fifo_din), .busy(busy),
`ifdef API_TX_ARB_STAT_EN
        .stat_clr(stat_clr), .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1),
`endif
        .cur_src(cur_src)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Source FIFO contents (driven to DUT), model mirrors, captured and expected tx streams.
    logic [31:0] q0[$], q1[$], m0[$], m1[$], got[$], exp_q[$];
    logic        pend0, pend1;
    logic        mrr;
    int          mpkt0, mpkt1;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, req);
        end
    endtask

    task automatic refresh();
        src0_count = CW'(q0.size());
        src1_count = CW'(q1.size());
        src0_dout  = (q0.size() > 0) ? q0[0] : 32'h0;
        src1_dout  = (q1.size() > 0) ? q1[0] : 32'h0;
    endtask

    // Source words carry their source id in bit 31 so mixing within a packet is visible.
    task automatic push_words(input int s, input int n);
        logic [31:0] d;
        for (int i = 0; i < n; i++) begin
            d = ($urandom() & 32'h7fff_ffff) | (32'(s) << 31);
            if (s == 0) begin q0.push_back(d); m0.push_back(d); end
            else        begin q1.push_back(d); m1.push_back(d); end
        end
        refresh();
    endtask

    task automatic model_grant(output int w);
        bit ok0, ok1;
        ok0 = reg_src_en[0] && (m0.size() >= WL);
        ok1 = reg_src_en[1] && (m1.size() >= WL);
        w = -1;
        if (ok0 || ok1) begin
            if (reg_strict) w = ok0 ? 0 : 1;
            else if (mrr == 1'b0) w = ok0 ? 0 : 1;
            else w = ok1 ? 1 : 0;
            mrr = (w == 0);
            for (int i = 0; i < WL; i++)
                exp_q.push_back((w == 0) ? m0.pop_front() : m1.pop_front());
            if (w == 0) mpkt0++; else mpkt1++;
        end
    endtask

    task automatic predict_all(output int g);
        int w;
        g = 0;
        do begin
            model_grant(w);
            if (w >= 0) g++;
        end while (w >= 0);
    endtask

    task automatic chk_stream(input string tag);
        int n;
        chk($sformatf("%s_len", tag), 32'(got.size()), 32'(exp_q.size()));
        n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            chk($sformatf("%s_w%0d", tag, i), got[i], exp_q[i]);
        got.delete();
        exp_q.delete();
    endtask

    task automatic chk_stats(input string tag);
`ifdef API_TX_ARB_STAT_EN
        chk({tag, "_pkt0"}, 32'(pkt_cnt0), 32'(mpkt0));
        chk({tag, "_pkt1"}, 32'(pkt_cnt1), 32'(mpkt1));
`else
        chk({tag, "_idle"}, 32'(busy), 32'(0));
`endif
    endtask

    task automatic clear_all();
        q0.delete(); q1.delete(); m0.delete(); m1.delete();
        got.delete(); exp_q.delete();
        refresh();
    endtask

    always @(negedge clk) begin
        pend0 <= src0_rd_en;
        pend1 <= src1_rd_en;
        if (tx_fifo_wr_en) got.push_back(tx_fifo_din);
    end

    // Pop just after the edge the DUT sampled rd_en on.
    always @(posedge clk) begin
        #1;
        if (rst_n) begin
            if (pend0 && q0.size() > 0) void'(q0.pop_front());
            if (pend1 && q1.size() > 0) void'(q1.pop_front());
            refresh();
        end
    end

    initial begin
        int g, w, first_rd, last_rd, n_rd, first_wr, n_wr, n_busy, last_busy, n_rd1, seen;
        bit found;
        rst_n = 1'b0; reg_src_en = 2'b00; reg_strict = 1'b0; tx_fifo_data_count = '0;
        pend0 = 1'b0; pend1 = 1'b0; mrr = 1'b0; mpkt0 = 0; mpkt1 = 0;
`ifdef API_TX_ARB_STAT_EN
        stat_clr = 1'b0;
`endif
        clear_all();
        repeat (3) @(negedge clk);
        chk("rst_rd0", 32'(src0_rd_en), 0);
        chk("rst_rd1", 32'(src1_rd_en), 0);
        chk("rst_wr", 32'(tx_fifo_wr_en), 0);
        chk("rst_din", tx_fifo_din, 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_cur", 32'(cur_src), 0);
        chk_stats("rst");
        rst_n = 1'b1;
        @(negedge clk);

        // Single source, single packet: timing of rd/wr/busy.
        push_words(0, WL);
        reg_src_en = 2'b11;
        model_grant(w);
        first_rd = -1; last_rd = -1; n_rd = 0; first_wr = -1; n_wr = 0;
        n_busy = 0; last_busy = -1; n_rd1 = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (src0_rd_en) begin if (first_rd < 0) first_rd = i; last_rd = i; n_rd++; end
            if (src1_rd_en) n_rd1++;
            if (tx_fifo_wr_en) begin if (first_wr < 0) first_wr = i; n_wr++; end
            if (busy) begin n_busy++; last_busy = i; end
        end
        chk("t1_first_rd", 32'(first_rd), 0);
        chk("t1_rd_cnt", 32'(n_rd), WL);
        chk("t1_rd_contig", 32'(last_rd - first_rd + 1), WL);
        chk("t1_rd1_cnt", 32'(n_rd1), 0);
        chk("t1_wr_lat", 32'(first_wr), 32'(first_rd + 1));
        chk("t1_wr_cnt", 32'(n_wr), WL);
        chk("t1_busy_cnt", 32'(n_busy), WL + 2);
        chk("t1_busy_end", 32'(last_busy), 32'(last_rd + 2));
        chk("t1_cur", 32'(cur_src), 0);
        chk_stream("t1");

        // Round-robin with both sources holding two packets.
        push_words(0, 2 * WL); push_words(1, 2 * WL);
        reg_strict = 1'b0;
        predict_all(g);
        repeat (g * 26 + 10) @(negedge clk);
        chk_stream("rr");
        chk_stats("rr");

        // Strict priority with three packets each.
        push_words(0, 3 * WL); push_words(1, 3 * WL);
        reg_strict = 1'b1;
        predict_all(g);
        repeat (g * 26 + 10) @(negedge clk);
        chk_stream("strict");
        chk_stats("strict");
        reg_strict = 1'b0;

        // Short src1 never granted; disabling src0 mid-packet still finishes that packet.
        push_words(0, 2 * WL); push_words(1, WL - 1);
        reg_src_en = 2'b11;
        model_grant(w);
        seen = 0;
        for (int i = 0; i < 60 && seen < 10; i++) begin
            @(negedge clk);
            if (src0_rd_en) seen++;
        end
        chk("dis_reach10", 32'(seen), 10);
        reg_src_en = 2'b10;
        predict_all(g);
        repeat (50) @(negedge clk);
        chk("dis_idle", 32'(busy), 0);
        chk_stream("dis");

        // Tx space boundary: 22 free words blocks, 23 free words grants next cycle.
        tx_fifo_data_count = CW'(490);
        reg_src_en = 2'b11;
        repeat (10) @(negedge clk);
        chk("full_busy", 32'(busy), 0);
        chk("full_nowr", 32'(got.size()), 0);
        tx_fifo_data_count = CW'(489);
        model_grant(w);
        @(negedge clk);
        chk("space_busy", 32'(busy), 1);
        chk("space_rd0", 32'(src0_rd_en), 32'(w == 0));
        chk("space_rd1", 32'(src1_rd_en), 32'(w == 1));
        predict_all(g);
        repeat (40) @(negedge clk);
        chk_stream("space");
        tx_fifo_data_count = '0;

        // Randomized scenarios; leftovers carry over in both FIFOs and the model.
        for (int it = 0; it < 6; it++) begin
            push_words(0, int'($urandom_range(0, 60)));
            push_words(1, int'($urandom_range(0, 60)));
            reg_src_en = 2'($urandom_range(0, 3));
            reg_strict = 1'($urandom_range(0, 1));
            predict_all(g);
            repeat (g * 26 + 10) @(negedge clk);
            chk_stream($sformatf("rnd%0d", it));
        end
        chk_stats("rnd");

`ifdef API_TX_ARB_STAT_EN
        stat_clr = 1'b1;
        @(negedge clk);
        stat_clr = 1'b0;
        mpkt0 = 0; mpkt1 = 0;
        chk_stats("clr");
`endif

        // Async reset at word 5 of a src0 packet.
        reg_src_en = 2'b00;
        repeat (3) @(negedge clk);
        clear_all();
        push_words(0, WL);
        reg_src_en = 2'b01;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            if (src0_rd_en) found = 1'b1;
        end
        chk("ar_started", 32'(found), 1);
        repeat (5) @(negedge clk);
        chk("ar_pre_rd0", 32'(src0_rd_en), 1);
        #1 rst_n = 1'b0;
        #1;
        chk("ar_rd0", 32'(src0_rd_en), 0);
        chk("ar_wr", 32'(tx_fifo_wr_en), 0);
        chk("ar_busy", 32'(busy), 0);
        chk("ar_cur", 32'(cur_src), 0);
        @(negedge clk);
        reg_src_en = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;
        clear_all();
        mrr = 1'b0; mpkt0 = 0; mpkt1 = 0;
        chk("ar_idle", 32'(busy), 0);
        chk_stats("ar");
        push_words(0, WL); push_words(1, WL);
        reg_src_en = 2'b11; reg_strict = 1'b0;
        predict_all(g);
        repeat (g * 26 + 10) @(negedge clk);
        chk_stream("ar_post");
        chk_stats("ar_post");

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
